// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state/op encodings and defaults for the PC sequencer
package pc_sequencer_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int RAS_DEPTH_DEF = 4;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;
    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_JUMP   = 3'd4,
        OP_CALL   = 3'd5,
        OP_RET    = 3'd6,
        OP_HALT   = 3'd7
    } op_t;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: LIFO return-address stack; only the count is reset, entries are don't-care
module pc_ras #(
    parameter int W = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] top
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] cnt;
    logic [AW-1:0] tidx;
    assign tidx = AW'(cnt - 1'b1);
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign top = mem[tidx];
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else if (push) cnt <= cnt + 1'b1;
        else if (pop) cnt <= cnt - 1'b1;
    end
    always_ff @(posedge clk) begin
        if (push) mem[cnt[AW-1:0]] <= din;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle FETCH/DECODE/EXEC/MEM/WB control with next-PC mux and call/return stack
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pc_cur,
    input  logic              imem_ack,
    input  logic [2:0]        op_class,
    input  logic              br_taken,
    input  logic [DATA_W-1:0] br_offset,
    input  logic [DATA_W-1:0] jmp_target,
    input  logic              dmem_ack,
    output logic              pc_en,
    output logic [DATA_W-1:0] pc_next,
    output logic              ir_en,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              rf_we,
    output logic [2:0]        state,
    output logic              halted,
    output logic              stack_err
);
    state_t st, nst;
    op_t op_q, op_in;
    logic err_q, set_err, push, pop, full, empty;
    logic [DATA_W-1:0] top, pc_inc;
    assign op_in = op_t'(op_class);
    assign pc_inc = pc_cur + 1'b1;
    pc_ras #(.W(DATA_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(pc_inc),
        .full(full), .empty(empty), .top(top)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st <= S_FETCH;
            op_q <= OP_ALU;
            err_q <= 1'b0;
        end else begin
            st <= nst;
            if (st == S_DECODE) op_q <= op_in;
            err_q <= err_q | set_err;
        end
    end
    always_comb begin
        nst = st;
        push = 1'b0;
        pop = 1'b0;
        set_err = 1'b0;
        pc_en = 1'b0;
        pc_next = '0;
        ir_en = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we = 1'b0;
        rf_we = 1'b0;
        case (st)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_en = imem_ack;
                nst = imem_ack ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                nst = S_EXEC;
                case (op_in)
                    OP_HALT: nst = S_HALT;
                    OP_JUMP: begin
                        pc_en = 1'b1;
                        pc_next = jmp_target;
                        nst = S_FETCH;
                    end
                    OP_CALL: begin
                        push = !full;
                        set_err = full;
                        pc_en = !full;
                        pc_next = full ? '0 : jmp_target;
                        nst = full ? S_HALT : S_FETCH;
                    end
                    OP_RET: begin
                        pop = !empty;
                        set_err = empty;
                        pc_en = !empty;
                        pc_next = empty ? '0 : top;
                        nst = empty ? S_HALT : S_FETCH;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                nst = (op_q == OP_ALU) ? S_WB : S_MEM;
                if (op_q == OP_BRANCH) begin
                    pc_en = 1'b1;
                    pc_next = br_taken ? pc_cur + br_offset : pc_inc;
                    nst = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we = op_q == OP_STORE;
                if (dmem_ack) begin
                    pc_en = dmem_we;
                    pc_next = dmem_we ? pc_inc : '0;
                    nst = dmem_we ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                rf_we = 1'b1;
                pc_en = 1'b1;
                pc_next = pc_inc;
                nst = S_FETCH;
            end
            S_HALT: ;
            default: nst = S_FETCH;
        endcase
        // reset overrides every output, including a same-cycle ack
        if (!rst_n) begin
            push = 1'b0;
            pop = 1'b0;
            set_err = 1'b0;
            pc_en = 1'b0;
            pc_next = '0;
            ir_en = 1'b0;
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we = 1'b0;
            rf_we = 1'b0;
        end
    end
    assign state = rst_n ? st : S_FETCH;
    assign halted = rst_n && st == S_HALT;
    assign stack_err = rst_n && (err_q || set_err);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: instruction-level model (latency, retire PC, RAS queue) checked every cycle
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [15:0] pc_cur = '0, br_offset = '0, jmp_target = '0, pc_next;
    logic imem_ack = 1'b0, br_taken = 1'b0, dmem_ack = 1'b0;
    logic [2:0] op_class = '0, state;
    logic pc_en, ir_en, imem_req, dmem_req, dmem_we, rf_we, halted, stack_err;
    int errors = 0, checks = 0;
    logic [15:0] ras [$];
    logic active = 1'b0, m_halt = 1'b0, m_err = 1'b0, m_err_pre = 1'b0;
    int m_cyc = 0, m_last = 0;
    logic [15:0] m_next = '0, got_next = '0;
    int n_ir, n_ireq, n_rf, n_dreq, n_dwe;
    logic [2:0] st_log [32];
    pc_sequencer #(.DATA_W(16), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .imem_ack(imem_ack), .op_class(op_class),
        .br_taken(br_taken), .br_offset(br_offset), .jmp_target(jmp_target), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .pc_next(pc_next), .ir_en(ir_en), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .rf_we(rf_we), .state(state), .halted(halted), .stack_err(stack_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic ok, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (active) begin
            st_log[m_cyc] = state;
            n_ir += int'(ir_en);
            n_ireq += int'(imem_req);
            n_rf += int'(rf_we);
            n_dreq += int'(dmem_req);
            n_dwe += int'(dmem_we);
            if (m_cyc == m_last && !m_halt) begin
                chk("retire", pc_en === 1'b1 && pc_next === m_next, {15'd0, pc_en, pc_next}, {15'd0, 1'b1, m_next});
                got_next = pc_next;
            end else
                chk("no_retire", pc_en === 1'b0 && pc_next === 16'h0, {15'd0, pc_en, pc_next}, 32'h0);
            chk("halted_run", halted === 1'b0, 32'(halted), 32'h0);
            chk("stack_err_run", stack_err === (m_cyc == m_last ? m_err : m_err_pre), 32'(stack_err),
                32'(m_cyc == m_last ? m_err : m_err_pre));
        end
    end
    task automatic instr(input logic [2:0] op, input logic [15:0] pc, input logic tk, input logic [15:0] off,
                         input logic [15:0] tgt, input int iw, input int dw);
        int base;
        logic err;
        logic [15:0] nx;
        err = 1'b0;
        nx = pc + 16'd1;
        base = 2;
        case (op)
            OP_ALU: base = 4;
            OP_LOAD: base = 5 + dw;
            OP_STORE: base = 4 + dw;
            OP_BRANCH: begin
                base = 3;
                nx = tk ? pc + off : pc + 16'd1;
            end
            OP_JUMP: nx = tgt;
            OP_CALL: if (ras.size() < 4) begin
                ras.push_back(pc + 16'd1);
                nx = tgt;
            end else err = 1'b1;
            OP_RET: if (ras.size() > 0) nx = ras.pop_back();
                    else err = 1'b1;
            default: ;
        endcase
        m_err_pre = m_err;
        m_err = m_err | err;
        m_halt = err || op == OP_HALT;
        m_last = iw + base - 1;
        m_next = nx;
        got_next = 16'hxxxx;
        n_ir = 0; n_ireq = 0; n_rf = 0; n_dreq = 0; n_dwe = 0;
        pc_cur = pc; op_class = op; br_taken = tk; br_offset = off; jmp_target = tgt;
        for (int k = 0; k <= m_last; k++) begin
            m_cyc = k;
            imem_ack = k >= iw;
            dmem_ack = k >= iw + 3 + dw;
            active = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        active = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("post_state", state === (m_halt ? 3'd5 : 3'd0), 32'(state), m_halt ? 32'd5 : 32'd0);
        chk("post_flags", {halted, stack_err, pc_en, imem_req} === {m_halt, m_err, 1'b0, !m_halt},
            {28'd0, halted, stack_err, pc_en, imem_req}, {28'd0, m_halt, m_err, 1'b0, !m_halt});
        chk("ir_en_once", n_ir == 1, n_ir, 1);
        chk("imem_req_cnt", n_ireq == iw + 1, n_ireq, iw + 1);
        chk("rf_we_cnt", n_rf == ((op == OP_ALU || op == OP_LOAD) ? 1 : 0), n_rf, (op == OP_ALU || op == OP_LOAD) ? 1 : 0);
        chk("dmem_req_cnt", n_dreq == ((op == OP_LOAD || op == OP_STORE) ? dw + 1 : 0), n_dreq,
            (op == OP_LOAD || op == OP_STORE) ? dw + 1 : 0);
        chk("dmem_we_cnt", n_dwe == (op == OP_STORE ? dw + 1 : 0), n_dwe, op == OP_STORE ? dw + 1 : 0);
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("reset_outs", {pc_en, pc_next, ir_en, imem_req, dmem_req, dmem_we, rf_we, state, halted, stack_err} === 27'd0,
            {5'd0, pc_en, pc_next, ir_en, imem_req, dmem_req, dmem_we, rf_we, state, halted, stack_err}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        ras.delete();
        m_err = 1'b0;
        @(negedge clk);
        chk("reset_state", state === 3'd0 && halted === 1'b0 && stack_err === 1'b0 && imem_req === 1'b1,
            {24'd0, state, halted, stack_err, imem_req, 2'd0}, 32'h4);
        @(posedge clk);
        #1;
    endtask
    initial begin
        do_reset();
        instr(OP_ALU, 16'h0010, 1'b0, 16'h0, 16'h0, 0, 0);
        chk("alu_next", got_next === 16'h0011, got_next, 16'h0011);
        chk("alu_states", {st_log[0], st_log[1], st_log[2], st_log[3]} === 12'o0124,
            {20'd0, st_log[0], st_log[1], st_log[2], st_log[3]}, 32'o0124);
        instr(OP_BRANCH, 16'h0020, 1'b1, 16'hFFF0, 16'h0, 0, 0);
        chk("br_taken", got_next === 16'h0010, got_next, 16'h0010);
        chk("br_states", {st_log[0], st_log[1], st_log[2]} === 9'o012, {23'd0, st_log[0], st_log[1], st_log[2]}, 32'o012);
        instr(OP_BRANCH, 16'h0020, 1'b0, 16'hFFF0, 16'h0, 0, 0);
        chk("br_not_taken", got_next === 16'h0021, got_next, 16'h0021);
        instr(OP_LOAD, 16'h0030, 1'b0, 16'h0, 16'h0, 0, 3);
        chk("load_next", got_next === 16'h0031, got_next, 16'h0031);
        chk("load_wb", st_log[7] === 3'd4, 32'(st_log[7]), 32'd4);
        instr(OP_STORE, 16'h0040, 1'b0, 16'h0, 16'h0, 1, 0);
        chk("store_next", got_next === 16'h0041, got_next, 16'h0041);
        instr(OP_JUMP, 16'h0050, 1'b0, 16'h0, 16'h1234, 2, 0);
        chk("jump_next", got_next === 16'h1234, got_next, 16'h1234);
        instr(OP_CALL, 16'h0100, 1'b0, 16'h0, 16'h0200, 0, 0);
        chk("call_next", got_next === 16'h0200, got_next, 16'h0200);
        instr(OP_RET, 16'h0200, 1'b0, 16'h0, 16'h0, 0, 0);
        chk("ret_next", got_next === 16'h0101, got_next, 16'h0101);
        instr(OP_ALU, 16'hFFFF, 1'b0, 16'h0, 16'h0, 0, 0);
        chk("alu_wrap", got_next === 16'h0000, got_next, 16'h0000);
        instr(OP_BRANCH, 16'hFFF8, 1'b1, 16'h0010, 16'h0, 0, 0);
        chk("br_wrap", got_next === 16'h0008, got_next, 16'h0008);
        for (int i = 0; i < 5; i++) instr(OP_CALL, 16'((i + 1) << 8), 1'b0, 16'h0, 16'((i + 2) << 8), 0, 0);
        chk("call_overflow", halted === 1'b1 && stack_err === 1'b1, {30'd0, halted, stack_err}, 32'h3);
        do_reset();
        instr(OP_RET, 16'h0300, 1'b0, 16'h0, 16'h0, 0, 0);
        chk("ret_underflow", halted === 1'b1 && stack_err === 1'b1, {30'd0, halted, stack_err}, 32'h3);
        do_reset();
        op_class = OP_LOAD;
        imem_ack = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("mem_reached", dmem_req === 1'b1 && state === 3'd3, {28'd0, dmem_req, state}, 32'hB);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem", {pc_en, rf_we, dmem_req, pc_next} === 19'd0, {13'd0, pc_en, rf_we, dmem_req, pc_next}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dmem_ack = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_state", state === 3'd0 && imem_req === 1'b1 && pc_en === 1'b0 && rf_we === 1'b0,
            {26'd0, state, imem_req, pc_en, rf_we}, 32'h4);
        @(posedge clk);
        #1;
        instr(OP_HALT, 16'h0060, 1'b0, 16'h0, 16'h0, 0, 0);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("halt_sticky", state === 3'd5 && halted === 1'b1 && stack_err === 1'b0 && pc_en === 1'b0 && imem_req === 1'b0,
            {27'd0, state, halted, stack_err}, 32'h16);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multicycle control sequencer that owns the 16-bit program counter register's enable and next-value input.
It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and computes the next PC: PC+1, branch, jump, or return.
A small return-address stack serves CALL/RET.
It sits between the instruction decoder, ALU flags, memory handshakes and the PC register (clk, en, in[15:0], out[15:0]).

Parameters:
DATA_W, 16, PC/address width; all PC arithmetic is modulo 2^DATA_W.
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
pc_cur  in  DATA_W  current PC (PC register out).
imem_ack  in  1  instruction memory ready; IR data valid this cycle.
op_class  in  3  decoder class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 CALL, 6 RET, 7 HALT.
br_taken  in  1  branch condition from ALU flags; sampled in EXEC only.
br_offset  in  DATA_W  sign-extended branch offset.
jmp_target  in  DATA_W  absolute jump/call target.
dmem_ack  in  1  data memory access complete.
pc_en  out  1  PC register load enable.
pc_next  out  DATA_W  PC register input.
ir_en  out  1  instruction register load.
imem_req  out  1  instruction fetch request.
dmem_req  out  1  data memory request.
dmem_we  out  1  data write (STORE).
rf_we  out  1  register file write.
state  out  3  current state encoding (debug).
halted  out  1  sequencer stopped.
stack_err  out  1  sticky RAS overflow/underflow flag.

Behaviour:
- Reset: rst_n sampled low at posedge -> state=FETCH, RAS empty (count 0), stored op cleared, halted=0, stack_err=0.
- While rst_n low, all outputs forced 0; reset wins over any simultaneous ack.
- Outputs are combinational from state + inputs. Exactly one pc_en pulse per retired instruction; pc_en=0 otherwise and pc_next=0 when pc_en=0.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - imem_req=1.
  - imem_ack=0 -> stay.
  - imem_ack=1 -> ir_en=1, go DECODE.
- DECODE: op_class latched into op_q.
  - HALT -> go HALT.
  - JUMP -> pc_en=1, pc_next=jmp_target, go FETCH.
  - CALL:
    - RAS not full -> push pc_cur+1, pc_en=1, pc_next=jmp_target, go FETCH.
    - RAS full -> stack_err=1, go HALT, no push, no pc_en.
  - RET:
    - RAS not empty -> pop, pc_en=1, pc_next=popped value, go FETCH.
    - RAS empty -> stack_err=1, go HALT.
  - Otherwise -> go EXEC.
- EXEC (uses op_q):
  - ALU -> go WB.
  - LOAD/STORE -> go MEM.
  - BRANCH -> pc_en=1, pc_next = br_taken ? pc_cur+br_offset : pc_cur+1, go FETCH.
- MEM:
  - dmem_req=1, dmem_we=(op_q==STORE); held until dmem_ack.
  - On ack: LOAD -> go WB; STORE -> pc_en=1, pc_next=pc_cur+1, go FETCH.
- WB: rf_we=1, pc_en=1, pc_next=pc_cur+1, go FETCH (single cycle).
- HALT: halted=1; all other outputs 0; exit only by reset.
- Wrap-around: 0xFFFF+1=0x0000; pc_cur+br_offset is truncated to DATA_W.
- RAS: LIFO with count 0..RAS_DEPTH; full when count==RAS_DEPTH. Never simultaneous push/pop. Contents undefined after reset; only count matters.
- Per-instruction latency, ack on first request cycle:
  - JUMP/CALL/RET: 2 cycles.
  - BRANCH: 3 cycles.
  - ALU: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle on an ack adds 1.

Decomposition:
- Shared package: state encodings, op_class codes (OP_ALU..OP_HALT), DATA_W default.
- One sub-module: pc_ras (return-address stack: push, pop, full, empty, top). FSM and next-PC mux stay in pc_sequencer.

Test Plan:
- Reset then ALU with imem_ack/dmem_ack immediate, pc_cur=0x0010 -> states 0,1,2,4,0; rf_we and pc_en in WB, pc_next=0x0011; ir_en exactly once.
- BRANCH, pc_cur=0x0020, br_offset=0xFFF0: br_taken=1 -> pc_next=0x0010; br_taken=0 -> pc_next=0x0021; pc_en only in EXEC.
- LOAD with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then WB, pc_next=pc_cur+1; STORE -> dmem_we=1, no rf_we, no WB.
- CALL at 0x0100 to 0x0200, then RET -> pc_next 0x0200, then 0x0101. 5 nested CALLs with RAS_DEPTH=4 -> 5th sets stack_err=1, halted=1, no pc_en.
- RET with empty RAS -> stack_err=1, HALT. pc_cur=0xFFFF ALU -> pc_next=0x0000.
- rst_n low mid-MEM with dmem_ack=1 same cycle -> next state FETCH, no pc_en/rf_we issued, stack_err and halted cleared.
